// File: rtl/sya_pack_pkg.sv
// Shared definitions for the systolic-array input packer: FSM state encoding
// and the beat-count derivations used to size the assembly counter.
package sya_pack_pkg;

  typedef logic [0:0] state_t;

  // state | meaning
  // FILL  | assembling beats into the assembly register
  // FULL  | completed vector waiting for the output register
  localparam state_t ST_FILL = 1'b0;
  localparam state_t ST_FULL = 1'b1;

  function automatic int calc_beats(input int side_len, input int in_words);
    return side_len / in_words;
  endfunction

  function automatic int calc_cnt_width(input int beats);
    return $clog2(beats) + 1;
  endfunction

endpackage

// File: rtl/sya_pack.sv
// Packs narrow input beats into SIDE_LEN-lane vectors for the skew buffer.
// Optional SYA_PACK_STAT_EN adds a 16-bit popped-vector counter (vec_cnt).
module sya_pack
  import sya_pack_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int SIDE_LEN   = 16,
  parameter int IN_WORDS   = 4
) (
  input  logic                           clk,
  input  logic                           Rst,
  input  logic [IN_WORDS*DATA_WIDTH-1:0] in_din,
  input  logic                           in_vld,
  output logic                           in_rdy,
  input  logic                           in_last,
  output logic [SIDE_LEN*DATA_WIDTH-1:0] out_dout,
  output logic [SIDE_LEN-1:0]            out_mask,
  output logic                           out_vld,
  input  logic                           out_rdy,
  output logic                           out_last
`ifdef SYA_PACK_STAT_EN
  ,
  output logic [15:0]                    vec_cnt
`endif
);

  localparam int BEATS  = calc_beats(SIDE_LEN, IN_WORDS);
  localparam int CNT_W  = calc_cnt_width(BEATS);
  localparam int BEAT_W = IN_WORDS * DATA_WIDTH;

  state_t                         state;
  logic [CNT_W-1:0]               cnt;
  logic [SIDE_LEN*DATA_WIDTH-1:0] asm_data;
  logic [SIDE_LEN-1:0]            asm_mask;
  logic                           asm_last;

  logic                           xfer;
  logic                           accept;
  logic                           complete;
  logic [SIDE_LEN*DATA_WIDTH-1:0] asm_data_nxt;
  logic [SIDE_LEN-1:0]            asm_mask_nxt;

  always_comb begin
    xfer     = (state == ST_FULL) && (!out_vld || out_rdy);
    in_rdy   = (state == ST_FILL) || xfer;
    accept   = in_vld && in_rdy;
    complete = (cnt == CNT_W'(BEATS - 1)) || in_last;
    // The first beat of a vector starts from zero so lanes left unfilled by
    // an early in_last come out as zero data with a cleared mask bit.
    asm_data_nxt = (cnt == '0) ? '0 : asm_data;
    asm_mask_nxt = (cnt == '0) ? '0 : asm_mask;
    for (int b = 0; b < BEATS; b++) begin
      if (cnt == CNT_W'(b)) begin
        asm_data_nxt[b*BEAT_W +: BEAT_W]     = in_din;
        asm_mask_nxt[b*IN_WORDS +: IN_WORDS] = '1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (Rst) begin
      state    <= ST_FILL;
      cnt      <= '0;
      asm_data <= '0;
      asm_mask <= '0;
      asm_last <= 1'b0;
      out_dout <= '0;
      out_mask <= '0;
      out_last <= 1'b0;
      out_vld  <= 1'b0;
    end else begin
      if (accept) begin
        asm_data <= asm_data_nxt;
        asm_mask <= asm_mask_nxt;
        if (complete) begin
          cnt      <= '0;
          asm_last <= in_last;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end

      // A new vector can complete on the same edge the previous one leaves.
      if (accept && complete)
        state <= ST_FULL;
      else if (xfer)
        state <= ST_FILL;

      if (xfer) begin
        out_dout <= asm_data;
        out_mask <= asm_mask;
        out_last <= asm_last;
        out_vld  <= 1'b1;
      end else if (out_vld && out_rdy) begin
        out_vld <= 1'b0;
      end
    end
  end

`ifdef SYA_PACK_STAT_EN
  always_ff @(posedge clk) begin
    if (Rst)
      vec_cnt <= '0;
    else if (out_vld && out_rdy)
      vec_cnt <= vec_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_sya_pack.sv
// Self-checking bench for sya_pack: a cycle table for streaming cases plus
// hand sequences for backpressure, reset, single-beat vectors and vec_cnt.
module tb_sya_pack;

  logic         clk = 1'b0;
  logic         Rst;
  logic [31:0]  in_din;
  logic         in_vld, in_rdy, in_last;
  logic [127:0] out_dout;
  logic [15:0]  out_mask;
  logic         out_vld, out_rdy, out_last;

  logic [31:0]  b1_din;
  logic         b1_vld, b1_rdy, b1_in_last;
  logic [31:0]  b1_dout;
  logic [3:0]   b1_mask;
  logic         b1_ovld, b1_ordy, b1_olast;

`ifdef SYA_PACK_STAT_EN
  logic [15:0]  vec_cnt, b1_vec_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sya_pack #(.DATA_WIDTH(8), .SIDE_LEN(16), .IN_WORDS(4)) dut (
    .clk(clk), .Rst(Rst),
    .in_din(in_din), .in_vld(in_vld), .in_rdy(in_rdy), .in_last(in_last),
    .out_dout(out_dout), .out_mask(out_mask), .out_vld(out_vld),
    .out_rdy(out_rdy), .out_last(out_last)
`ifdef SYA_PACK_STAT_EN
    , .vec_cnt(vec_cnt)
`endif
  );

  sya_pack #(.DATA_WIDTH(8), .SIDE_LEN(4), .IN_WORDS(4)) dut_b1 (
    .clk(clk), .Rst(Rst),
    .in_din(b1_din), .in_vld(b1_vld), .in_rdy(b1_rdy), .in_last(b1_in_last),
    .out_dout(b1_dout), .out_mask(b1_mask), .out_vld(b1_ovld),
    .out_rdy(b1_ordy), .out_last(b1_olast)
`ifdef SYA_PACK_STAT_EN
    , .vec_cnt(b1_vec_cnt)
`endif
  );

  typedef struct {
    logic         rst, vld, last, ordy;
    logic [31:0]  din;
    logic         e_rdy, e_ovld, chk, e_last;
    logic [15:0]  e_mask;
    logic [127:0] e_dout;
  } row_t;

  localparam logic [127:0] V0    = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
  localparam logic [127:0] VTAIL = 128'h00000000_00000000_17161514_13121110;
  localparam logic [127:0] VA    = 128'h2F2E2D2C_2B2A2928_27262524_23222120;
  localparam logic [127:0] VB    = 128'h3F3E3D3C_3B3A3938_37363534_33323130;

  row_t rows[22];

  function automatic row_t r(input logic rst, vld, last, ordy, input logic [31:0] din,
                             input logic e_rdy, e_ovld, chk, e_last,
                             input logic [15:0] e_mask, input logic [127:0] e_dout);
    row_t x;
    x.rst = rst; x.vld = vld; x.last = last; x.ordy = ordy; x.din = din;
    x.e_rdy = e_rdy; x.e_ovld = e_ovld; x.chk = chk; x.e_last = e_last;
    x.e_mask = e_mask; x.e_dout = e_dout;
    return x;
  endfunction

  function automatic logic [31:0] w(input logic [7:0] base);
    return {base + 8'd3, base + 8'd2, base + 8'd1, base};
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rst_pulse();
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
  endtask

  task automatic send(input logic [31:0] d, input logic l);
    bit done = 0;
    in_din = d; in_vld = 1'b1; in_last = l;
    for (int t = 0; t < 50 && !done; t++) begin
      @(negedge clk);
      if (in_rdy) done = 1;
      tick();
    end
    in_vld = 1'b0; in_last = 1'b0;
    if (!done) begin
      n_cmp++; n_bad++;
      $display("FAIL send timeout: got no in_rdy want in_rdy");
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] got[2];
    int n, pops, acc;
    bit seen;

    Rst = 1'b1; in_din = '0; in_vld = 0; in_last = 0; out_rdy = 1;
    b1_din = '0; b1_vld = 0; b1_in_last = 0; b1_ordy = 1;
    tick();

    rows[0]  = r(1, 0, 0, 1, 32'h0,        1, 0, 1, 0, 16'h0000, 128'h0);
    rows[1]  = r(0, 1, 0, 1, 32'h03020100, 1, 0, 0, 0, 16'h0000, 128'h0);
    rows[2]  = r(0, 1, 0, 1, 32'h07060504, 1, 0, 0, 0, 16'h0000, 128'h0);
    rows[3]  = r(0, 1, 0, 1, 32'h0B0A0908, 1, 0, 0, 0, 16'h0000, 128'h0);
    rows[4]  = r(0, 1, 0, 1, 32'h0F0E0D0C, 1, 0, 0, 0, 16'h0000, 128'h0);
    rows[5]  = r(0, 0, 0, 1, 32'h0,        1, 1, 1, 0, 16'hFFFF, V0);
    rows[6]  = r(0, 0, 0, 1, 32'h0,        1, 0, 0, 0, 16'h0000, 128'h0);
    rows[7]  = r(0, 1, 0, 1, 32'h03020100, 1, 0, 0, 0, 16'h0000, 128'h0);
    rows[8]  = r(0, 1, 0, 1, 32'h07060504, 1, 0, 0, 0, 16'h0000, 128'h0);
    rows[9]  = r(0, 1, 0, 1, 32'h0B0A0908, 1, 0, 0, 0, 16'h0000, 128'h0);
    rows[10] = r(0, 1, 0, 1, 32'h0F0E0D0C, 1, 0, 0, 0, 16'h0000, 128'h0);
    rows[11] = r(0, 1, 0, 1, 32'h13121110, 1, 1, 1, 0, 16'hFFFF, V0);
    rows[12] = r(0, 1, 1, 1, 32'h17161514, 1, 0, 0, 0, 16'h0000, 128'h0);
    rows[13] = r(0, 0, 0, 1, 32'h0,        1, 1, 1, 1, 16'h00FF, VTAIL);
    rows[14] = r(0, 0, 0, 1, 32'h0,        1, 0, 0, 0, 16'h0000, 128'h0);
    rows[15] = r(0, 1, 0, 1, 32'h03020100, 1, 0, 0, 0, 16'h0000, 128'h0);
    rows[16] = r(0, 1, 0, 1, 32'h07060504, 1, 0, 0, 0, 16'h0000, 128'h0);
    rows[17] = r(0, 1, 0, 1, 32'h0B0A0908, 1, 0, 0, 0, 16'h0000, 128'h0);
    rows[18] = r(0, 1, 1, 1, 32'h0F0E0D0C, 1, 0, 0, 0, 16'h0000, 128'h0);
    rows[19] = r(0, 0, 0, 1, 32'h0,        1, 1, 1, 1, 16'hFFFF, V0);
    rows[20] = r(0, 0, 0, 1, 32'h0,        1, 0, 0, 0, 16'h0000, 128'h0);
    rows[21] = r(0, 0, 0, 1, 32'h0,        1, 0, 0, 0, 16'h0000, 128'h0);

    for (int i = 0; i < 22; i++) begin
      Rst = rows[i].rst; in_vld = rows[i].vld; in_last = rows[i].last;
      out_rdy = rows[i].ordy; in_din = rows[i].din;
      tick();
      chk($sformatf("row%0d out_vld", i), out_vld, rows[i].e_ovld);
      chk($sformatf("row%0d in_rdy", i), in_rdy, rows[i].e_rdy);
      if (rows[i].chk) begin
        chk($sformatf("row%0d out_dout", i), out_dout, rows[i].e_dout);
        chk($sformatf("row%0d out_mask", i), out_mask, rows[i].e_mask);
        chk($sformatf("row%0d out_last", i), out_last, rows[i].e_last);
      end
    end
    Rst = 0; in_vld = 0; in_last = 0;

    // Backpressure: eight beats offered with out_rdy low.
    rst_pulse();
    out_rdy = 1'b0;
    n = 0;
    for (int t = 0; t < 40 && n < 8; t++) begin
      in_din = w(8'(8'h20 + 8'(4 * n))); in_vld = 1'b1;
      @(negedge clk);
      if (in_rdy) n++;
      tick();
    end
    in_din = w(8'h40);
    chk("bp accepted beats", 128'(n), 128'd8);
    chk("bp in_rdy low", in_rdy, 1'b0);
    chk("bp out_vld", out_vld, 1'b1);
    chk("bp out_dout", out_dout, VA);
    for (int t = 0; t < 3; t++) begin
      tick();
      chk($sformatf("bp hold%0d dout", t), out_dout, VA);
      chk($sformatf("bp hold%0d in_rdy", t), in_rdy, 1'b0);
    end
    in_vld = 1'b0; out_rdy = 1'b1;
    pops = 0;
    for (int t = 0; t < 10 && pops < 2; t++) begin
      @(negedge clk);
      if (out_vld) begin
        got[pops] = out_dout;
        chk($sformatf("bp pop%0d mask", pops), out_mask, 16'hFFFF);
        pops++;
      end
      tick();
    end
    chk("bp pop count", 128'(pops), 128'd2);
    chk("bp first vector", got[0], VA);
    chk("bp second vector", got[1], VB);
    tick();
    chk("bp drained out_vld", out_vld, 1'b0);

    // Reset after two beats; reset also wins over an offered beat.
    rst_pulse();
    send(w(8'hA0), 1'b0);
    send(w(8'hB0), 1'b0);
    Rst = 1'b1; in_vld = 1'b1; in_din = w(8'hC0);
    tick();
    Rst = 1'b0; in_vld = 1'b0;
    chk("rst out_vld", out_vld, 1'b0);
    chk("rst in_rdy", in_rdy, 1'b1);
    chk("rst out_mask", out_mask, 16'h0);
    chk("rst out_dout", out_dout, 128'h0);
    send(w(8'h00), 1'b0);
    send(w(8'h04), 1'b0);
    send(w(8'h08), 1'b0);
    send(w(8'h0C), 1'b0);
    seen = 0;
    for (int t = 0; t < 5 && !seen; t++) begin
      @(negedge clk);
      if (out_vld) begin
        seen = 1;
        chk("post-rst dout", out_dout, V0);
        chk("post-rst mask", out_mask, 16'hFFFF);
        chk("post-rst last", out_last, 1'b0);
      end
      tick();
    end
    if (!seen) begin
      n_cmp++; n_bad++;
      $display("FAIL post-rst vector: got none want one");
    end

    // One-beat vectors: full rate with out_rdy held high.
    rst_pulse();
    b1_ordy = 1'b1; b1_vld = 1'b1;
    acc = 0; pops = 0;
    for (int t = 0; t < 12; t++) begin
      b1_vld = (acc < 8);
      b1_din = 32'hA000 + 32'(acc);
      @(negedge clk);
      if (b1_vld) chk($sformatf("b1 in_rdy c%0d", t), b1_rdy, 1'b1);
      if (b1_vld && b1_rdy) acc++;
      if (b1_ovld) begin
        chk($sformatf("b1 pop%0d data", pops), b1_dout, 32'hA000 + 32'(pops));
        chk($sformatf("b1 pop%0d mask", pops), b1_mask, 4'hF);
        pops++;
      end
      tick();
    end
    b1_vld = 1'b0;
    chk("b1 accepted", 128'(acc), 128'd8);
    chk("b1 popped", 128'(pops), 128'd8);

`ifdef SYA_PACK_STAT_EN
    rst_pulse();
    chk("vec_cnt after rst", vec_cnt, 16'd0);
    out_rdy = 1'b1;
    for (int i = 0; i < 12; i++) send(w(8'(4 * i)), 1'b0);
    for (int t = 0; t < 4; t++) tick();
    chk("vec_cnt three pops", vec_cnt, 16'd3);
    rst_pulse();
    chk("vec_cnt cleared", vec_cnt, 16'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sya_pack.md
SYA_PACK -- requirements
Module: sya_pack

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, bits per element.
REQ-002 SHALL have parameter SIDE_LEN, default 16, elements per output vector (systolic side length).
REQ-003 SHALL have parameter IN_WORDS, default 4, elements per input beat; SIDE_LEN % IN_WORDS == 0 required.
REQ-004 SHALL have ports: clk  in  1  single clock; all logic on its rising edge.
REQ-005 SHALL have ports: Rst  in  1  reset, synchronous and active-high.
REQ-006 SHALL have ports: in_din  in  IN_WORDS*DATA_WIDTH  input beat, word 0 in the lowest bits; in_vld  in  1; in_rdy  out  1; in_last  in  1  final beat of a stream.
REQ-007 SHALL have ports: out_dout  out  SIDE_LEN*DATA_WIDTH  packed vector, feeds the skew buffer; out_mask  out  SIDE_LEN  per-lane valid; out_vld  out  1; out_rdy  in  1; out_last  out  1  final vector of a stream.

Function
REQ-008 SHALL transfer on the input when in_vld && in_rdy and on the output when out_vld && out_rdy, sampled at the rising clk edge.
REQ-009 SHALL place accepted beat b (b = 0..BEATS-1, BEATS = SIDE_LEN/IN_WORDS) in lanes b*IN_WORDS .. b*IN_WORDS+IN_WORDS-1 of the assembly register.
REQ-010 SHALL keep a beat counter of width clog2(BEATS)+1 that increments per accepted beat and clears to 0 on vector completion.
REQ-011 SHALL complete a vector on the accepted beat with counter == BEATS-1 or with in_last=1.
REQ-012 SHALL zero the data of unfilled lanes of a vector completed by in_last and clear their out_mask bits; filled lanes' mask bits = 1.
REQ-013 SHALL NOT emit an extra empty vector when in_last coincides with beat BEATS-1.
REQ-014 SHALL use FSM states FILL (assembling) and FULL (completed vector waiting); FILL->FULL on completion; FULL->FILL on transfer to the output register.
REQ-015 SHALL move the assembly register to the output register at an edge where state==FULL and (!out_vld || out_rdy), setting out_vld=1 after that edge.
REQ-016 SHALL drive in_rdy = (state==FILL) || (state==FULL && transfer condition of REQ-015), combinationally.
REQ-017 SHALL give a latency of 2 edges: completing beat accepted at edge k -> out_vld high after edge k+1 when the output slot is free.
REQ-018 SHALL sustain one beat per cycle with out_rdy held high, including BEATS==1.
REQ-019 SHALL hold out_dout, out_mask and out_last stable while out_vld && !out_rdy.
REQ-020 SHALL clear out_vld after a pop edge with no simultaneous transfer.

Reset
REQ-021 SHALL, after an edge with Rst=1, set out_vld=0, out_last=0, out_mask=0, out_dout=0, beat counter=0, state=FILL, and discard any partial vector.
REQ-022 SHALL have Rst take priority over every simultaneous handshake; in_rdy=1 in the cycle after reset.

Configuration
REQ-023 SHALL, with SYA_PACK_STAT_EN defined, add output vec_cnt (16 bits), incremented per output pop, wrapping 0xFFFF->0, cleared by Rst.
REQ-024 SHALL, without SYA_PACK_STAT_EN, omit vec_cnt and its counter entirely; all other behaviour identical.

Structure
REQ-025 SHALL take the FSM state enum (FILL, FULL) and BEATS derivation from the shared SYA package.
REQ-026 SHALL be a single module with no sub-modules; the assembly and output registers are inline.

Verification
REQ-027 SHALL cover: 4 beats 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C, out_rdy=1 -> out_dout lanes 0..15 = 0x00..0x0F, mask=0xFFFF, out_vld 2 edges after beat 4.
REQ-028 SHALL cover: 6 beats, in_last on beat 6 -> vector 1 mask 0xFFFF last=0; vector 2 lanes 0..7 valid, lanes 8..15 = 0, mask=0x00FF, last=1.
REQ-029 SHALL cover: in_last on beat 4 -> exactly one vector, mask 0xFFFF, last=1, no trailing vector.
REQ-030 SHALL cover: out_rdy=0 with 8 beats offered -> in_rdy drops after beat 8, out_dout stable; out_rdy=1 -> both vectors delivered in order, none lost.
REQ-031 SHALL cover: Rst pulsed after 2 beats -> out_vld=0, next 4 beats form a fresh vector, no stale lanes.
REQ-032 SHALL cover, with SYA_PACK_STAT_EN: 3 vectors popped -> vec_cnt=3; Rst -> vec_cnt=0.
